multi_clk_gen: RTL

- Synthesisable, parametrised multi-channel clock/strobe generator.
- Replaces the task-based behavioural clock generation used in benches.
- Derives CH independent divided outputs from one system clock. Each output has a programmable period, high time and phase.
- Supports glitch-free enable/disable, shadowed reconfiguration, and a global phase-realign strobe. Sits beside bench/DUT tops as the shared clock/strobe source.

---
 rtl/multi_clk_gen_pkg.sv | 40 ++++
 rtl/multi_clk_gen_ch.sv | 134 +++++++++++++
 rtl/multi_clk_gen.sv | 65 ++++++
 3 files changed

// File: rtl/multi_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe generator.
// Latency: n/a (types, constants and a pure validation function).
// Backpressure: n/a.
package multi_clk_gen_pkg;

    // Per-channel lifecycle: stopped, producing periods, finishing the last period
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    // Default field width for users that want a ready-made config struct
    localparam int CFG_W = 8;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

    localparam int unsigned RESET_PERIOD = 2;
    localparam int unsigned RESET_HIGH   = 1;
    localparam int unsigned RESET_PHASE  = 0;

    localparam cfg_t RESET_CFG = '{
        period: CFG_W'(RESET_PERIOD),
        high:   CFG_W'(RESET_HIGH),
        phase:  CFG_W'(RESET_PHASE)
    };

    // A config is usable only if it yields at least one high and one low cycle
    // and the start phase lands inside the period.
    function automatic logic cfg_ok(input int unsigned period,
                                    input int unsigned high,
                                    input int unsigned phase);
        return (period >= 2) && (high != 0) && (high < period) && (phase < period);
    endfunction

endpackage

// File: rtl/multi_clk_gen_ch.sv
// One divided-clock channel: FSM, counter, active/pending config, registered outputs.
// Latency: en/sync sampled at edge k change clk_out at edge k (visible cycle k+1).
// Backpressure: none; config writes are always absorbed (direct load or pending slot).
module multi_clk_gen_ch
    import multi_clk_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_period_i,
    input  logic [CNT_W-1:0] wr_high_i,
    input  logic [CNT_W-1:0] wr_phase_i,
    input  logic             en_i,
    input  logic             sync_i,
    output logic             clk_out_o,
    output logic             rise_tick_o,
    output logic             running_o
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } ch_cfg_t;

    localparam ch_cfg_t RST_CFG = '{
        period: CNT_W'(RESET_PERIOD),
        high:   CNT_W'(RESET_HIGH),
        phase:  CNT_W'(RESET_PHASE)
    };

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;

    ch_cfg_t wr_cfg;
    ch_cfg_t idle_cfg;
    ch_cfg_t nxt_cfg;
    logic    wrap;

    assign wr_cfg = '{period: wr_period_i, high: wr_high_i, phase: wr_phase_i};
    assign wrap   = (cnt_q == (act_q.period - CNT_W'(1)));
    // Config used when leaving IDLE: a fresh write beats a stranded pending entry
    assign idle_cfg = wr_i ? wr_cfg : (pend_vld_q ? pend_q : act_q);
    // Config in force after this edge while counting: pending is only taken at a wrap
    assign nxt_cfg  = (wrap && pend_vld_q) ? pend_q : act_q;

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= RST_CFG;
            pend_q     <= RST_CFG;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
        end
    end

    // Next-state: disabling at the last cycle of a period stops straight away,
    // otherwise the remainder of the period is drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (en_i) state_d = RUN;
            RUN, DRAIN: begin
                if (en_i)      state_d = RUN;
                else if (wrap) state_d = IDLE;
                else           state_d = DRAIN;
            end
            default:    state_d = IDLE;
        endcase
    end

    // Counter, config slots and output level for the next cycle
    always_comb begin
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        if (state_q == IDLE) begin
            act_d      = idle_cfg;
            pend_vld_d = 1'b0;
            if (en_i) begin
                cnt_d = idle_cfg.phase;
                clk_d = (idle_cfg.phase < idle_cfg.high);
            end else begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
        end else begin
            if (wrap && pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
            end
            // A write landing on a wrap edge waits for the following wrap
            if (wr_i) begin
                pend_d     = wr_cfg;
                pend_vld_d = 1'b1;
            end
            if (!en_i && wrap) begin
                cnt_d = '0;
                clk_d = 1'b0;
            end else begin
                if ((state_q == RUN) && en_i && sync_i) cnt_d = nxt_cfg.phase;
                else if (wrap)                          cnt_d = '0;
                else                                    cnt_d = cnt_q + CNT_W'(1);
                clk_d = (cnt_d < nxt_cfg.high);
            end
        end
        rise_d = !clk_q && clk_d;
    end

    assign clk_out_o   = clk_q;
    assign rise_tick_o = rise_q;
    assign running_o   = (state_q != IDLE);

endmodule

// File: rtl/multi_clk_gen.sv
// Multi-channel clock/strobe generator: write decode, validation, sync fan-out.
// Latency: cfg_err one cycle after the write; channel outputs registered (see channel).
// Backpressure: none; invalid writes are dropped and flagged on cfg_err.
module multi_clk_gen
    import multi_clk_gen_pkg::*;
#(
    parameter int CH    = 2,
    parameter int CNT_W = 8,
    parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CH-1:0]    en,
    input  logic             sync_start,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    rise_tick,
    output logic [CH-1:0]    running,
    output logic             cfg_err
);

    logic          wr_ok;
    logic [CH-1:0] wr_sel;
    logic          cfg_err_q, cfg_err_d;

    // Validate the write and steer it to exactly one channel
    always_comb begin
        wr_ok = cfg_ok(32'(cfg_period), 32'(cfg_high), 32'(cfg_phase))
                && (32'(cfg_ch) < 32'(CH));
        cfg_err_d = cfg_we && !wr_ok;
        wr_sel    = '0;
        for (int i = 0; i < CH; i++) begin
            wr_sel[i] = cfg_we && wr_ok && (32'(cfg_ch) == 32'(i));
        end
    end

    // One-cycle rejection pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        multi_clk_gen_ch #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_i        (wr_sel[g]),
            .wr_period_i (cfg_period),
            .wr_high_i   (cfg_high),
            .wr_phase_i  (cfg_phase),
            .en_i        (en[g]),
            .sync_i      (sync_start),
            .clk_out_o   (clk_out[g]),
            .rise_tick_o (rise_tick[g]),
            .running_o   (running[g])
        );
    end

endmodule
